// File: rtl/asip_pkg.sv
// Shared types and constants for the ASIP result path.
package asip_pkg;

  localparam logic [7:0] HeaderDefault = 8'hA5;

  localparam int unsigned FrameLenCsum   = 6;
  localparam int unsigned FrameLenNoCsum = 5;

  localparam int unsigned IdxWidth = 3;
  typedef logic [IdxWidth-1:0] byte_idx_t;

  typedef enum logic {
    StIdle = 1'b0,
    StSend = 1'b1
  } framer_state_e;

endpackage

// File: rtl/asip_result_slot.sv
// 32-bit result holding register with valid flag; load wins over clear.
module asip_result_slot (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        load_i,
  input  logic        clear_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        valid_o
);

  logic [31:0] data_q;
  logic        valid_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      data_q  <= 32'h0;
      valid_q <= 1'b0;
    end else if (load_i) begin
      data_q  <= data_i;
      valid_q <= 1'b1;
    end else if (clear_i) begin
      valid_q <= 1'b0;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/asip_result_framer.sv
// Serialises ASIP results as HEADER,MAX,MIN,QUOTIENT,REMAINDER[,CHECKSUM] byte frames.
// Define RESULT_CHECKSUM_EN to append the XOR checksum byte.
module asip_result_framer
  import asip_pkg::*;
#(
  parameter logic [7:0] HEADER = HeaderDefault
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       DONE,
  input  logic [7:0] MAX,
  input  logic [7:0] MIN,
  input  logic [7:0] QUOTIENT,
  input  logic [7:0] REMAINDER,
  output logic [7:0] TX_DATA,
  output logic       TX_VALID,
  input  logic       TX_READY,
  output logic       BUSY,
  output logic       OVERRUN,
  output logic [7:0] FRAME_COUNT
);

`ifdef RESULT_CHECKSUM_EN
  localparam byte_idx_t LastIdx = byte_idx_t'(FrameLenCsum - 1);
`else
  localparam byte_idx_t LastIdx = byte_idx_t'(FrameLenNoCsum - 1);
`endif

  framer_state_e state_q, state_d;
  byte_idx_t     idx_q, idx_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          tx_valid_q, tx_valid_d;
  logic          overrun_q, overrun_d;
  logic [7:0]    count_q, count_d;

  logic [31:0] res_in, act_data, pend_data, next_data;
  logic        act_valid, pend_valid;
  logic        act_load, act_clear, pend_load, pend_clear;
  logic        load_byte, xfer, last_xfer;

  assign res_in = {MAX, MIN, QUOTIENT, REMAINDER};

  function automatic logic [7:0] frame_byte(logic [31:0] r, byte_idx_t i);
    logic [7:0] b;
    case (i)
      3'd0:    b = HEADER;
      3'd1:    b = r[31:24];
      3'd2:    b = r[23:16];
      3'd3:    b = r[15:8];
      3'd4:    b = r[7:0];
`ifdef RESULT_CHECKSUM_EN
      3'd5:    b = r[31:24] ^ r[23:16] ^ r[15:8] ^ r[7:0];
`endif
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  asip_result_slot u_active (
    .clk_i   (CLK),
    .rst_ni  (RESET),
    .load_i  (act_load),
    .clear_i (act_clear),
    .data_i  (next_data),
    .data_o  (act_data),
    .valid_o (act_valid)
  );

  asip_result_slot u_pending (
    .clk_i   (CLK),
    .rst_ni  (RESET),
    .load_i  (pend_load),
    .clear_i (pend_clear),
    .data_i  (res_in),
    .data_o  (pend_data),
    .valid_o (pend_valid)
  );

  assign xfer      = tx_valid_q & TX_READY & act_valid;
  assign last_xfer = xfer & (idx_q == LastIdx);

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    tx_valid_d = tx_valid_q;
    overrun_d  = overrun_q;
    count_d    = count_q;
    act_load   = 1'b0;
    act_clear  = 1'b0;
    pend_load  = 1'b0;
    pend_clear = 1'b0;
    load_byte  = 1'b0;
    next_data  = act_data;

    case (state_q)
      StIdle: begin
        if (DONE) begin
          act_load   = 1'b1;
          next_data  = res_in;
          state_d    = StSend;
          idx_d      = '0;
          tx_valid_d = 1'b1;
          load_byte  = 1'b1;
        end
      end
      StSend: begin
        if (last_xfer) begin
          count_d = count_q + 8'd1;
          // Pending occupancy before this edge decides who owns the next frame.
          if (pend_valid) begin
            act_load   = 1'b1;
            pend_clear = 1'b1;
            next_data  = pend_data;
            idx_d      = '0;
            load_byte  = 1'b1;
            if (DONE) overrun_d = 1'b1;
          end else if (DONE) begin
            act_load  = 1'b1;
            next_data = res_in;
            idx_d     = '0;
            load_byte = 1'b1;
          end else begin
            act_clear  = 1'b1;
            state_d    = StIdle;
            idx_d      = '0;
            tx_valid_d = 1'b0;
          end
        end else begin
          if (xfer) begin
            idx_d     = idx_q + byte_idx_t'(1);
            load_byte = 1'b1;
          end
          if (DONE) begin
            if (pend_valid) overrun_d = 1'b1;
            else            pend_load = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    tx_data_d = load_byte ? frame_byte(next_data, idx_d) : tx_data_q;
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
      count_q    <= 8'h00;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      overrun_q  <= overrun_d;
      count_q    <= count_d;
    end
  end

  assign TX_DATA     = tx_data_q;
  assign TX_VALID    = tx_valid_q;
  assign BUSY        = (state_q == StSend) | pend_valid;
  assign OVERRUN     = overrun_q;
  assign FRAME_COUNT = count_q;

endmodule

// File: tb/tb_asip_result_framer.sv
// Directed bench for asip_result_framer; frame length follows RESULT_CHECKSUM_EN.
module tb_asip_result_framer;

`ifdef RESULT_CHECKSUM_EN
  localparam int FL = 6;
`else
  localparam int FL = 5;
`endif

  logic       CLK = 1'b0;
  logic       RESET = 1'b0;
  logic       DONE = 1'b0;
  logic [7:0] MAX = '0, MIN = '0, QUOTIENT = '0, REMAINDER = '0;
  logic [7:0] TX_DATA;
  logic       TX_VALID;
  logic       TX_READY = 1'b0;
  logic       BUSY, OVERRUN;
  logic [7:0] FRAME_COUNT;

  asip_result_framer dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .DONE        (DONE),
    .MAX         (MAX),
    .MIN         (MIN),
    .QUOTIENT    (QUOTIENT),
    .REMAINDER   (REMAINDER),
    .TX_DATA     (TX_DATA),
    .TX_VALID    (TX_VALID),
    .TX_READY    (TX_READY),
    .BUSY        (BUSY),
    .OVERRUN     (OVERRUN),
    .FRAME_COUNT (FRAME_COUNT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0] mx, mn, q, r, csum;
  } vec_t;
  vec_t vt[4];

  int passed = 0;
  int total  = 0;
  logic [7:0] rxq[$];
  logic [7:0] exp_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic logic [7:0] exp_byte(int v, int k);
    case (k)
      0:       return 8'hA5;
      1:       return vt[v].mx;
      2:       return vt[v].mn;
      3:       return vt[v].q;
      4:       return vt[v].r;
      default: return vt[v].csum;
    endcase
  endfunction

  // Collect accepted bytes and check hold-during-stall, away from the clock edge.
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data  = '0;
  always @(negedge CLK) begin
    if (prev_stall && RESET) begin
      check("stall_valid", {31'b0, TX_VALID}, 32'd1);
      check("stall_data", {24'b0, TX_DATA}, {24'b0, prev_data});
    end
    if (RESET && TX_VALID && TX_READY) rxq.push_back(TX_DATA);
    prev_stall = RESET && TX_VALID && !TX_READY;
    prev_data  = TX_DATA;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_done(input int v);
    MAX = vt[v].mx; MIN = vt[v].mn; QUOTIENT = vt[v].q; REMAINDER = vt[v].r;
    DONE = 1'b1;
    tick();
    DONE = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (BUSY && n < 500) begin
      tick();
      n++;
    end
    check("idle_timeout", {31'b0, BUSY}, 32'd0);
  endtask

  task automatic check_frames(input string name, input int a, input int b, input int nfr);
    check({name, "_len"}, rxq.size(), nfr * FL);
    if (rxq.size() == nfr * FL) begin
      for (int k = 0; k < FL; k++) check({name, "_f0"}, {24'b0, rxq[k]}, {24'b0, exp_byte(a, k)});
      if (nfr > 1)
        for (int k = 0; k < FL; k++)
          check({name, "_f1"}, {24'b0, rxq[FL+k]}, {24'b0, exp_byte(b, k)});
    end
  endtask

  task automatic check_reset_vals(input string name);
    check({name, "_data"}, {24'b0, TX_DATA}, 32'h0);
    check({name, "_valid"}, {31'b0, TX_VALID}, 32'd0);
    check({name, "_busy"}, {31'b0, BUSY}, 32'd0);
    check({name, "_overrun"}, {31'b0, OVERRUN}, 32'd0);
    check({name, "_count"}, {24'b0, FRAME_COUNT}, 32'd0);
  endtask

  initial begin
    int n;
    vt[0] = '{8'h7F, 8'h02, 8'h21, 8'h01, 8'h5D};
    vt[1] = '{8'h10, 8'h01, 8'h08, 8'h00, 8'h19};
    vt[2] = '{8'hFF, 8'h00, 8'hAA, 8'h55, 8'h00};
    vt[3] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h08};
    exp_cnt = 8'd0;

    tick(); tick();
    RESET = 1'b1;
    tick();
    check_reset_vals("reset");

    // Table: one frame per vector with the sink always ready.
    TX_READY = 1'b1;
    for (int v = 0; v < 4; v++) begin
      rxq.delete();
      do_done(v);
      check("hdr_latency", {31'b0, TX_VALID}, 32'd1);
      wait_idle(n);
      exp_cnt++;
      check("frame_cycles", n, FL);
      check_frames("table", v, v, 1);
      check("table_count", {24'b0, FRAME_COUNT}, {24'b0, exp_cnt});
      check("table_valid_low", {31'b0, TX_VALID}, 32'd0);
    end

    // Stalling sink: ready pattern 1,0,0,1,0,0,...
    rxq.delete();
    do_done(0);
    n = 0;
    while (BUSY && n < 500) begin
      TX_READY = (n % 3 == 0);
      tick();
      n++;
    end
    check("stall_timeout", {31'b0, BUSY}, 32'd0);
    exp_cnt++;
    TX_READY = 1'b1;
    check_frames("stall", 0, 0, 1);

    // Second result arrives mid-frame: follows with no gap.
    rxq.delete();
    do_done(0);
    tick();
    do_done(1);
    wait_idle(n);
    exp_cnt += 2;
    check("b2b_cycles", n + 2, 2 * FL);
    check_frames("b2b", 0, 1, 2);
    check("b2b_overrun", {31'b0, OVERRUN}, 32'd0);

    // DONE on the last-byte transfer with pending empty.
    rxq.delete();
    do_done(2);
    for (int i = 0; i < FL - 1; i++) tick();
    do_done(3);
    wait_idle(n);
    exp_cnt += 2;
    check("last_cycles", n + FL, 2 * FL);
    check_frames("last_empty", 2, 3, 2);
    check("last_overrun", {31'b0, OVERRUN}, 32'd0);

    // DONE on the last-byte transfer with pending full: new result dropped.
    rxq.delete();
    TX_READY = 1'b0;
    do_done(0);
    do_done(1);
    TX_READY = 1'b1;
    for (int i = 0; i < FL - 1; i++) tick();
    do_done(2);
    wait_idle(n);
    exp_cnt += 2;
    check_frames("last_full", 0, 1, 2);
    check("last_full_overrun", {31'b0, OVERRUN}, 32'd1);
    check("last_full_count", {24'b0, FRAME_COUNT}, {24'b0, exp_cnt});

    // Three DONEs while stalled: third dropped, overrun stays set.
    rxq.delete();
    TX_READY = 1'b0;
    do_done(3);
    do_done(2);
    do_done(1);
    TX_READY = 1'b1;
    wait_idle(n);
    exp_cnt += 2;
    check_frames("three", 3, 2, 2);
    check("three_overrun", {31'b0, OVERRUN}, 32'd1);
    check("three_count", {24'b0, FRAME_COUNT}, {24'b0, exp_cnt});

    // Reset after the third byte aborts the frame.
    do_done(0);
    tick(); tick(); tick();
    RESET = 1'b0;
    tick();
    RESET = 1'b1;
    check_reset_vals("midreset");
    tick();
    check("midreset_idle", {31'b0, TX_VALID}, 32'd0);
    rxq.delete();
    do_done(1);
    check("fresh_hdr", {24'b0, TX_DATA}, 32'hA5);
    wait_idle(n);
    exp_cnt = 8'd1;
    check_frames("fresh", 1, 1, 1);
    check("fresh_count", {24'b0, FRAME_COUNT}, 32'd1);

    // 255 more frames wrap the counter to zero.
    for (int i = 0; i < 255; i++) begin
      do_done(i % 4);
      wait_idle(n);
      exp_cnt++;
    end
    check("wrap_count", {24'b0, FRAME_COUNT}, {24'b0, exp_cnt});
    check("wrap_zero", {24'b0, FRAME_COUNT}, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
